// File: rtl/serial_router_pkg.sv
// Shared types and constants for the serial port router.
// Optional feature macro: PARITY_CHECK_EN adds the PAR state.
package serial_router_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
`ifdef PARITY_CHECK_EN
    PAR  = 3'd4,
`endif
    DONE = 3'd5
  } state_t;

  // Hex digit to segments {g,f,e,d,c,b,a}, active-high; entry 0 is rightmost.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex-to-7-segment decoder.
module ssd_hex_decoder
  import serial_router_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[hex];

endmodule

// File: rtl/serial_port_router.sv
// Framed serial receiver that routes payload bits to one of NUM_CH ports.
// Frame: start(0) | addr (ADDR_W, MSB first) | len (CNT_W, MSB first) | payload.
// Optional feature macro: PARITY_CHECK_EN appends an even-parity bit per frame.
module serial_port_router
  import serial_router_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              SerIn,
  output logic              SerOutValid,
  output logic              Done,
  output logic              Err,
  output logic [NUM_CH-1:0] P,
  output logic [6:0]        SSD_Out
);

  localparam int BW = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_W - 1);
  localparam logic [BW-1:0] LEN_LAST  = BW'(CNT_W - 1);
`ifdef PARITY_CHECK_EN
  localparam state_t END_ST = PAR;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [BW-1:0]     bcnt;
  logic              in_range;
  logic [ADDR_W-1:0] addr_shift;
  logic [CNT_W-1:0]  len_shift;

  assign in_range   = (int'(addr) < NUM_CH);
  assign addr_shift = ADDR_W'({addr, SerIn});
  assign len_shift  = CNT_W'({cnt, SerIn});

  // Next-state logic; DONE leaves unconditionally so the pulse lasts one clk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (clkEn && !SerIn) state_nxt = ADDR;
      ADDR: if (clkEn && bcnt == ADDR_LAST) state_nxt = LEN;
      LEN:  if (clkEn && bcnt == LEN_LAST)
              state_nxt = (len_shift != '0) ? DATA : END_ST;
      DATA: if (clkEn && cnt == CNT_W'(1)) state_nxt = END_ST;
`ifdef PARITY_CHECK_EN
      PAR:  if (clkEn) state_nxt = DONE;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign SerOutValid = (state == DATA) && in_range;
  assign Done        = (state == DONE);

  // Port demux: only the addressed port follows SerIn.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_port
    assign P[i] = SerOutValid && (addr == ADDR_W'(i)) && SerIn;
  end

`ifdef PARITY_CHECK_EN
  logic par_acc, err_q;
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  // Field shifters, bit counter and payload counter; advance on enabled edges only.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
      bcnt <= '0;
`ifdef PARITY_CHECK_EN
      par_acc <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else if (clkEn) begin
      case (state)
        IDLE: if (!SerIn) begin
          bcnt <= '0;
`ifdef PARITY_CHECK_EN
          par_acc <= 1'b0;
          err_q   <= 1'b0;
`endif
        end
        ADDR: begin
          addr <= addr_shift;
          bcnt <= (bcnt == ADDR_LAST) ? '0 : bcnt + 1'b1;
        end
        LEN: begin
          cnt  <= len_shift;
          bcnt <= bcnt + 1'b1;
        end
        DATA: begin
          cnt <= cnt - 1'b1;
`ifdef PARITY_CHECK_EN
          if (in_range) par_acc <= par_acc ^ SerIn;
`endif
        end
`ifdef PARITY_CHECK_EN
        PAR: err_q <= par_acc ^ SerIn;
`endif
        default: ;
      endcase
    end
  end

  ssd_hex_decoder u_ssd (
    .hex (4'(cnt)),
    .seg (SSD_Out)
  );

endmodule

// File: tb/tb_serial_port_router.sv
// Directed self-checking bench for serial_port_router (default and NUM_CH=3).
module tb_serial_port_router;

  logic       clk, rst, clkEn, SerIn;
  logic       v, d, e;
  logic [3:0] p;
  logic [6:0] ssd;
  logic       v3, d3, e3;
  logic [2:0] p3;
  logic [6:0] ssd3;

  int n_tests = 0, n_fail = 0;
  int vcnt = 0, dcnt = 0;

  serial_port_router dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(SerIn),
    .SerOutValid(v), .Done(d), .Err(e), .P(p), .SSD_Out(ssd)
  );

  serial_port_router #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(SerIn),
    .SerOutValid(v3), .Done(d3), .Err(e3), .P(p3), .SSD_Out(ssd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enabled valid cycles and Done pulses of the default instance.
  always @(negedge clk) begin
    if (clkEn && v) vcnt++;
    if (d) dcnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic b);
    SerIn = b;
    clkEn = 1'b1;
    edge_wait();
  endtask

  task automatic send_hdr(input logic [1:0] a, input logic [3:0] l);
    tick(1'b0);
    for (int i = 1; i >= 0; i--) tick(a[i]);
    for (int i = 3; i >= 0; i--) tick(l[i]);
  endtask

  task automatic data_bit(input string tag, input logic b, input logic [3:0] exp_p,
                          input logic exp_v, input logic [6:0] exp_ssd);
    SerIn = b;
    clkEn = 1'b1;
    #1;
    check({tag, "_p"}, 32'(p), 32'(exp_p));
    check({tag, "_v"}, 32'(v), 32'(exp_v));
    check({tag, "_ssd"}, 32'(ssd), 32'(exp_ssd));
    edge_wait();
  endtask

  task automatic finish_frame(input string tag, input logic pbit, input logic exp_err);
`ifdef PARITY_CHECK_EN
    tick(pbit);
    SerIn = 1'b1;
`else
    SerIn = pbit;
`endif
    clkEn = 1'b1;
    check({tag, "_done"}, 32'(d), 32'd1);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_ssd0"}, 32'(ssd), 32'h3F);
    edge_wait();
    SerIn = 1'b1;
    check({tag, "_done_off"}, 32'(d), 32'd0);
  endtask

  initial begin
    int vbase;
    rst = 1'b1; clkEn = 1'b0; SerIn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_v", 32'(v), 32'd0);
    check("rst_done", 32'(d), 32'd0);
    check("rst_err", 32'(e), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_ssd", 32'(ssd), 32'h3F);
    check("rst_p3", 32'(p3), 32'd0);

    // idle line: nothing happens
    tick(1'b1); tick(1'b1);
    check("idle_v", 32'(v), 32'd0);

    // frame 0|11|0011|1,0,1
    send_hdr(2'd3, 4'd3);
    check("t1_len_ssd", 32'(ssd), 32'h4F);
    vbase = vcnt;
    data_bit("t1_b0", 1'b1, 4'b1000, 1'b1, 7'h4F);
    data_bit("t1_b1", 1'b0, 4'b0000, 1'b1, 7'h5B);
    data_bit("t1_b2", 1'b1, 4'b1000, 1'b1, 7'h06);
    check("t1_v_off", 32'(v), 32'd0);
    finish_frame("t1", 1'b0, 1'b0);
    check("t1_vcnt", 32'(vcnt - vbase), 32'd3);
    check("t1_dcnt", 32'(dcnt), 32'd1);

    // frame 0|01|0000: no payload
    vbase = vcnt;
    send_hdr(2'd1, 4'd0);
    check("t2_v", 32'(v), 32'd0);
    finish_frame("t2", 1'b0, 1'b0);
    check("t2_vcnt", 32'(vcnt - vbase), 32'd0);
    check("t2_dcnt", 32'(dcnt), 32'd2);

    // frame 0|10|0010|1,1 with a 5-clk stall mid-payload
    send_hdr(2'd2, 4'd2);
    check("t3_len_ssd", 32'(ssd), 32'h5B);
    data_bit("t3_b0", 1'b1, 4'b0100, 1'b1, 7'h5B);
    SerIn = 1'b1; clkEn = 1'b0;
    repeat (5) edge_wait();
    check("t3_stall_ssd", 32'(ssd), 32'h06);
    check("t3_stall_v", 32'(v), 32'd1);
    check("t3_stall_p", 32'(p), 32'b0100);
    check("t3_stall_dcnt", 32'(dcnt), 32'd2);
    data_bit("t3_b1", 1'b1, 4'b0100, 1'b1, 7'h06);
    finish_frame("t3", 1'b0, 1'b0);
    check("t3_dcnt", 32'(dcnt), 32'd3);

    // frame 0|00|0101 aborted by rst during DATA
    send_hdr(2'd0, 4'd5);
    data_bit("t4_b0", 1'b1, 4'b0001, 1'b1, 7'h6D);
    data_bit("t4_b1", 1'b0, 4'b0000, 1'b1, 7'h66);
    rst = 1'b1; SerIn = 1'b1; clkEn = 1'b1;
    edge_wait();
    rst = 1'b0;
    check("t4_rst_p", 32'(p), 32'd0);
    check("t4_rst_v", 32'(v), 32'd0);
    check("t4_rst_ssd", 32'(ssd), 32'h3F);
    check("t4_rst_done", 32'(d), 32'd0);
    tick(1'b1);
    check("t4_rst_dcnt", 32'(dcnt), 32'd3);
    send_hdr(2'd0, 4'd1);
    data_bit("t4b_b0", 1'b1, 4'b0001, 1'b1, 7'h06);
    finish_frame("t4b", 1'b1, 1'b0);
    check("t4b_dcnt", 32'(dcnt), 32'd4);

    // NUM_CH=3 instance, frame 0|11|0010|1,1: out of range
    send_hdr(2'd3, 4'd2);
    for (int i = 0; i < 2; i++) begin
      SerIn = 1'b1; clkEn = 1'b1;
      #1;
      check("t5_p3", 32'(p3), 32'd0);
      check("t5_v3", 32'(v3), 32'd0);
      check("t5_ssd3", 32'(ssd3), (i == 0) ? 32'h5B : 32'h06);
      edge_wait();
    end
`ifdef PARITY_CHECK_EN
    tick(1'b0);
`endif
    check("t5_done3", 32'(d3), 32'd1);
    check("t5_err3", 32'(e3), 32'd0);
    edge_wait();
    check("t5_done3_off", 32'(d3), 32'd0);

`ifdef PARITY_CHECK_EN
    // frame 0|00|0011|1,1,0|1: bad parity
    send_hdr(2'd0, 4'd3);
    data_bit("tp_b0", 1'b1, 4'b0001, 1'b1, 7'h4F);
    data_bit("tp_b1", 1'b1, 4'b0001, 1'b1, 7'h5B);
    data_bit("tp_b2", 1'b0, 4'b0000, 1'b1, 7'h06);
    finish_frame("tp", 1'b1, 1'b1);
    check("tp_err_hold", 32'(e), 32'd1);
    send_hdr(2'd0, 4'd1);
    check("tp_err_clr", 32'(e), 32'd0);
    data_bit("tp2_b0", 1'b1, 4'b0001, 1'b1, 7'h06);
    finish_frame("tp2", 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
